rename_alias_table: RTL and testbench

RENAME_ALIAS_TABLE -- requirements
Module: rename_alias_table

---
 rtl/rename_alias_table.sv | 249 ++++++++++++++++++++++++
 tb/tb_rename_alias_table.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_alias_table.sv
// Three-wide register rename stage: speculative and committed alias tables,
// intra-group bypass, free-list allocation handshake and one output register.
module rename_alias_table #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              lane_valid_0,
    input  logic              lane_valid_1,
    input  logic              lane_valid_2,
    input  logic [4:0]        rs1_0,
    input  logic [4:0]        rs1_1,
    input  logic [4:0]        rs1_2,
    input  logic [4:0]        rs2_0,
    input  logic [4:0]        rs2_1,
    input  logic [4:0]        rs2_2,
    input  logic [4:0]        rd_0,
    input  logic [4:0]        rd_1,
    input  logic [4:0]        rd_2,
    input  logic              rd_we_0,
    input  logic              rd_we_1,
    input  logic              rd_we_2,
    input  logic [5:0]        free_count,
    output logic              alloc_en_0,
    output logic              alloc_en_1,
    output logic              alloc_en_2,
    input  logic [PHYS_W-1:0] alloc_tag_0,
    input  logic [PHYS_W-1:0] alloc_tag_1,
    input  logic [PHYS_W-1:0] alloc_tag_2,
    input  logic              alloc_valid_0,
    input  logic              alloc_valid_1,
    input  logic              alloc_valid_2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_lane_valid_0,
    output logic              out_lane_valid_1,
    output logic              out_lane_valid_2,
    output logic              out_rd_we_0,
    output logic              out_rd_we_1,
    output logic              out_rd_we_2,
    output logic [PHYS_W-1:0] out_prs1_0,
    output logic [PHYS_W-1:0] out_prs1_1,
    output logic [PHYS_W-1:0] out_prs1_2,
    output logic [PHYS_W-1:0] out_prs2_0,
    output logic [PHYS_W-1:0] out_prs2_1,
    output logic [PHYS_W-1:0] out_prs2_2,
    output logic [PHYS_W-1:0] out_prd_0,
    output logic [PHYS_W-1:0] out_prd_1,
    output logic [PHYS_W-1:0] out_prd_2,
    output logic [PHYS_W-1:0] out_old_prd_0,
    output logic [PHYS_W-1:0] out_old_prd_1,
    output logic [PHYS_W-1:0] out_old_prd_2,
    input  logic              commit_en_0,
    input  logic              commit_en_1,
    input  logic              commit_en_2,
    input  logic [4:0]        commit_rd_0,
    input  logic [4:0]        commit_rd_1,
    input  logic [4:0]        commit_rd_2,
    input  logic [PHYS_W-1:0] commit_prd_0,
    input  logic [PHYS_W-1:0] commit_prd_1,
    input  logic [PHYS_W-1:0] commit_prd_2,
    input  logic              flush
);

    localparam int LANES = 3;

    logic [LANES-1:0]  lv;
    logic [LANES-1:0]  we;
    logic [LANES-1:0]  need;
    logic [LANES-1:0]  alloc;
    logic [LANES-1:0]  cen;
    logic [4:0]        rs1 [LANES];
    logic [4:0]        rs2 [LANES];
    logic [4:0]        rd [LANES];
    logic [4:0]        crd [LANES];
    logic [PHYS_W-1:0] tag [LANES];
    logic [PHYS_W-1:0] cprd [LANES];

    logic [PHYS_W-1:0] spec_map [ARCH_REGS];
    logic [PHYS_W-1:0] com_map [ARCH_REGS];
    logic [PHYS_W-1:0] com_next [ARCH_REGS];

    logic [PHYS_W-1:0] p1 [LANES];
    logic [PHYS_W-1:0] p2 [LANES];
    logic [PHYS_W-1:0] pd [LANES];
    logic [PHYS_W-1:0] po [LANES];

    logic [LANES-1:0]  held_lv;
    logic [LANES-1:0]  held_we;
    logic [PHYS_W-1:0] held_p1 [LANES];
    logic [PHYS_W-1:0] held_p2 [LANES];
    logic [PHYS_W-1:0] held_pd [LANES];
    logic [PHYS_W-1:0] held_po [LANES];

    logic [1:0] need_cnt;
    logic       adv;
    logic       fire;

    assign lv = {lane_valid_2, lane_valid_1, lane_valid_0};
    assign we = {rd_we_2, rd_we_1, rd_we_0};
    assign cen = {commit_en_2, commit_en_1, commit_en_0};

    assign rs1[0] = rs1_0;
    assign rs1[1] = rs1_1;
    assign rs1[2] = rs1_2;
    assign rs2[0] = rs2_0;
    assign rs2[1] = rs2_1;
    assign rs2[2] = rs2_2;
    assign rd[0] = rd_0;
    assign rd[1] = rd_1;
    assign rd[2] = rd_2;
    assign tag[0] = alloc_tag_0;
    assign tag[1] = alloc_tag_1;
    assign tag[2] = alloc_tag_2;
    assign crd[0] = commit_rd_0;
    assign crd[1] = commit_rd_1;
    assign crd[2] = commit_rd_2;
    assign cprd[0] = commit_prd_0;
    assign cprd[1] = commit_prd_1;
    assign cprd[2] = commit_prd_2;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            need[k] = lv[k] & we[k] & (rd[k] != 5'd0);
        end
    end

    assign need_cnt = 2'(need[0]) + 2'(need[1]) + 2'(need[2]);
    assign adv = !out_valid | out_ready;
    assign in_ready = adv & !flush & !rst
                    & ({4'b0, need_cnt} <= free_count);
    assign fire = in_valid & in_ready;
    assign alloc = {LANES{fire}} & need;

    assign alloc_en_0 = alloc[0];
    assign alloc_en_1 = alloc[1];
    assign alloc_en_2 = alloc[2];

    // Later lanes in the loop override earlier ones, so the youngest
    // earlier producer of a register supplies the bypassed tag.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            p1[k] = spec_map[rs1[k]];
            p2[k] = spec_map[rs2[k]];
            po[k] = spec_map[rd[k]];
            for (int j = 0; j < k; j++) begin
                if (need[j] && rd[j] == rs1[k]) p1[k] = tag[j];
                if (need[j] && rd[j] == rs2[k]) p2[k] = tag[j];
                if (need[j] && rd[j] == rd[k]) po[k] = tag[j];
            end
            if (rs1[k] == 5'd0) p1[k] = '0;
            if (rs2[k] == 5'd0) p2[k] = '0;
            if (!need[k]) po[k] = '0;
            pd[k] = need[k] ? tag[k] : '0;
        end
    end

    always_comb begin
        for (int i = 0; i < ARCH_REGS; i++) begin
            com_next[i] = com_map[i];
        end
        for (int k = 0; k < LANES; k++) begin
            if (cen[k] && crd[k] != 5'd0) com_next[crd[k]] = cprd[k];
        end
    end

    // Recovery copies the committed map as it stands after this
    // cycle's retirements, so a commit racing the flush is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                spec_map[i] <= PHYS_W'(i);
                com_map[i] <= PHYS_W'(i);
            end
        end else begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                com_map[i] <= com_next[i];
            end
            if (flush) begin
                for (int i = 0; i < ARCH_REGS; i++) begin
                    spec_map[i] <= com_next[i];
                end
            end else if (fire) begin
                for (int k = 0; k < LANES; k++) begin
                    if (need[k]) spec_map[rd[k]] <= tag[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            held_lv <= '0;
            held_we <= '0;
            for (int k = 0; k < LANES; k++) begin
                held_p1[k] <= '0;
                held_p2[k] <= '0;
                held_pd[k] <= '0;
                held_po[k] <= '0;
            end
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (fire) begin
            out_valid <= 1'b1;
            held_lv <= lv;
            held_we <= we;
            for (int k = 0; k < LANES; k++) begin
                held_p1[k] <= p1[k];
                held_p2[k] <= p2[k];
                held_pd[k] <= pd[k];
                held_po[k] <= po[k];
            end
        end else if (adv) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(alloc[0] && !alloc_valid_0));
            assert (!(alloc[1] && !alloc_valid_1));
            assert (!(alloc[2] && !alloc_valid_2));
        end
    end

    assign out_lane_valid_0 = held_lv[0];
    assign out_lane_valid_1 = held_lv[1];
    assign out_lane_valid_2 = held_lv[2];
    assign out_rd_we_0 = held_we[0];
    assign out_rd_we_1 = held_we[1];
    assign out_rd_we_2 = held_we[2];
    assign out_prs1_0 = held_p1[0];
    assign out_prs1_1 = held_p1[1];
    assign out_prs1_2 = held_p1[2];
    assign out_prs2_0 = held_p2[0];
    assign out_prs2_1 = held_p2[1];
    assign out_prs2_2 = held_p2[2];
    assign out_prd_0 = held_pd[0];
    assign out_prd_1 = held_pd[1];
    assign out_prd_2 = held_pd[2];
    assign out_old_prd_0 = held_po[0];
    assign out_old_prd_1 = held_po[1];
    assign out_old_prd_2 = held_po[2];

endmodule

// File: tb/tb_rename_alias_table.sv
// Randomized and directed bench for rename_alias_table against a
// sequential-rename reference model.
module tb_rename_alias_table;

    logic clk = 1'b0;
    logic rst, in_valid, out_ready, flush;
    logic in_ready, out_valid;
    logic [5:0] free_count;
    logic lv [3];
    logic we [3];
    logic av [3];
    logic cen [3];
    logic [4:0] rs1 [3];
    logic [4:0] rs2 [3];
    logic [4:0] rd [3];
    logic [4:0] crd [3];
    logic [5:0] tag [3];
    logic [5:0] cprd [3];

    logic alloc_en_0, alloc_en_1, alloc_en_2;
    logic out_lane_valid_0, out_lane_valid_1, out_lane_valid_2;
    logic out_rd_we_0, out_rd_we_1, out_rd_we_2;
    logic [5:0] out_prs1_0, out_prs1_1, out_prs1_2;
    logic [5:0] out_prs2_0, out_prs2_1, out_prs2_2;
    logic [5:0] out_prd_0, out_prd_1, out_prd_2;
    logic [5:0] out_old_prd_0, out_old_prd_1, out_old_prd_2;

    logic [25:0] obs_lane [3];

    logic [5:0]  ms [32];
    logic [5:0]  mc [32];
    logic        m_ov;
    logic [25:0] m_lane [3];

    logic       obs_ready;
    logic [2:0] obs_alloc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rename_alias_table dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .lane_valid_0(lv[0]), .lane_valid_1(lv[1]), .lane_valid_2(lv[2]),
        .rs1_0(rs1[0]), .rs1_1(rs1[1]), .rs1_2(rs1[2]),
        .rs2_0(rs2[0]), .rs2_1(rs2[1]), .rs2_2(rs2[2]),
        .rd_0(rd[0]), .rd_1(rd[1]), .rd_2(rd[2]),
        .rd_we_0(we[0]), .rd_we_1(we[1]), .rd_we_2(we[2]),
        .free_count(free_count),
        .alloc_en_0(alloc_en_0), .alloc_en_1(alloc_en_1),
        .alloc_en_2(alloc_en_2),
        .alloc_tag_0(tag[0]), .alloc_tag_1(tag[1]), .alloc_tag_2(tag[2]),
        .alloc_valid_0(av[0]), .alloc_valid_1(av[1]),
        .alloc_valid_2(av[2]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_valid_0(out_lane_valid_0),
        .out_lane_valid_1(out_lane_valid_1),
        .out_lane_valid_2(out_lane_valid_2),
        .out_rd_we_0(out_rd_we_0), .out_rd_we_1(out_rd_we_1),
        .out_rd_we_2(out_rd_we_2),
        .out_prs1_0(out_prs1_0), .out_prs1_1(out_prs1_1),
        .out_prs1_2(out_prs1_2),
        .out_prs2_0(out_prs2_0), .out_prs2_1(out_prs2_1),
        .out_prs2_2(out_prs2_2),
        .out_prd_0(out_prd_0), .out_prd_1(out_prd_1),
        .out_prd_2(out_prd_2),
        .out_old_prd_0(out_old_prd_0), .out_old_prd_1(out_old_prd_1),
        .out_old_prd_2(out_old_prd_2),
        .commit_en_0(cen[0]), .commit_en_1(cen[1]), .commit_en_2(cen[2]),
        .commit_rd_0(crd[0]), .commit_rd_1(crd[1]), .commit_rd_2(crd[2]),
        .commit_prd_0(cprd[0]), .commit_prd_1(cprd[1]),
        .commit_prd_2(cprd[2]),
        .flush(flush)
    );

    always_comb begin
        obs_lane[0] = {out_lane_valid_0, out_rd_we_0, out_prs1_0,
                       out_prs2_0, out_prd_0, out_old_prd_0};
        obs_lane[1] = {out_lane_valid_1, out_rd_we_1, out_prs1_1,
                       out_prs2_1, out_prd_1, out_old_prd_1};
        obs_lane[2] = {out_lane_valid_2, out_rd_we_2, out_prs1_2,
                       out_prs2_2, out_prd_2, out_old_prd_2};
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic need(input int k);
        return lv[k] && we[k] && rd[k] != 5'd0;
    endfunction

    task automatic idle();
        rst = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        free_count = 6'd20;
        for (int k = 0; k < 3; k++) begin
            lv[k] = 1'b0;
            we[k] = 1'b0;
            av[k] = 1'b1;
            cen[k] = 1'b0;
            rs1[k] = '0;
            rs2[k] = '0;
            rd[k] = '0;
            crd[k] = '0;
            tag[k] = '0;
            cprd[k] = '0;
        end
    endtask

    // One clock: handshake checks before the edge, model step, then
    // registered-output checks just after the edge.
    task automatic cycle();
        int nc;
        logic ir, adv, fire;
        logic [2:0] ae;
        logic [5:0] p1, p2, pd, po;
        #1;
        nc = 0;
        for (int k = 0; k < 3; k++) nc += need(k) ? 1 : 0;
        adv = !m_ov || out_ready;
        ir = !rst && adv && !flush && (nc <= int'(free_count));
        fire = ir && in_valid;
        ae = {need(2), need(1), need(0)} & {3{fire}};
        obs_ready = in_ready;
        obs_alloc = {alloc_en_2, alloc_en_1, alloc_en_0};
        check("in_ready", {31'd0, in_ready}, {31'd0, ir});
        check("alloc_en", {29'd0, obs_alloc}, {29'd0, ae});
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                ms[i] = 6'(i);
                mc[i] = 6'(i);
            end
            m_ov = 1'b0;
            for (int k = 0; k < 3; k++) m_lane[k] = '0;
        end else begin
            for (int k = 0; k < 3; k++)
                if (cen[k] && crd[k] != 0) mc[crd[k]] = cprd[k];
            if (flush) begin
                m_ov = 1'b0;
                for (int i = 0; i < 32; i++) ms[i] = mc[i];
            end else if (fire) begin
                m_ov = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    p1 = (rs1[k] == 0) ? 6'd0 : ms[rs1[k]];
                    p2 = (rs2[k] == 0) ? 6'd0 : ms[rs2[k]];
                    pd = 6'd0;
                    po = 6'd0;
                    if (need(k)) begin
                        po = ms[rd[k]];
                        pd = tag[k];
                        ms[rd[k]] = tag[k];
                    end
                    m_lane[k] = {lv[k], we[k], p1, p2, pd, po};
                end
            end else if (adv) begin
                m_ov = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        for (int k = 0; k < 3; k++)
            check($sformatf("lane%0d", k), {6'd0, obs_lane[k]},
                  {6'd0, m_lane[k]});
    endtask

    initial begin
        m_ov = 1'b0;
        for (int k = 0; k < 3; k++) m_lane[k] = '0;
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        check("rst_ready", {31'd0, obs_ready}, 32'd0);
        idle();

        // post-reset rename
        in_valid = 1'b1;
        lv[0] = 1'b1; rs1[0] = 5'd3; rd[0] = 5'd5; we[0] = 1'b1;
        tag[0] = 6'd32;
        cycle();
        check("t39_prs1", {26'd0, out_prs1_0}, 32'd3);
        check("t39_prd", {26'd0, out_prd_0}, 32'd32);
        check("t39_old", {26'd0, out_old_prd_0}, 32'd5);

        // intra-group dependency
        idle();
        in_valid = 1'b1;
        lv[0] = 1'b1; rd[0] = 5'd7; we[0] = 1'b1; tag[0] = 6'd40;
        lv[1] = 1'b1; rs1[1] = 5'd7; rd[1] = 5'd7; we[1] = 1'b1;
        tag[1] = 6'd41;
        lv[2] = 1'b1; rs2[2] = 5'd7;
        cycle();
        check("t40_prs1_1", {26'd0, out_prs1_1}, 32'd40);
        check("t40_old_1", {26'd0, out_old_prd_1}, 32'd40);
        check("t40_prs2_2", {26'd0, out_prs2_2}, 32'd41);
        idle();
        in_valid = 1'b1;
        lv[0] = 1'b1; rs1[0] = 5'd7;
        cycle();
        check("t40_map7", {26'd0, out_prs1_0}, 32'd41);

        // allocation stall then release
        idle();
        in_valid = 1'b1;
        free_count = 6'd1;
        for (int k = 0; k < 3; k++) begin
            lv[k] = 1'b1; we[k] = 1'b1; rd[k] = 5'(k + 1);
            tag[k] = 6'(42 + k);
        end
        cycle();
        check("t41_stall_rdy", {31'd0, obs_ready}, 32'd0);
        check("t41_stall_en", {29'd0, obs_alloc}, 32'd0);
        free_count = 6'd3;
        cycle();
        check("t41_fire_en", {29'd0, obs_alloc}, 32'd7);

        // output backpressure
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            lv[k] = 1'b0; we[k] = 1'b0;
        end
        lv[0] = 1'b1; we[0] = 1'b1; rd[0] = 5'd9; tag[0] = 6'd45;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("t42_rdy", {31'd0, obs_ready}, 32'd0);
            check("t42_en", {29'd0, obs_alloc}, 32'd0);
            check("t42_hold0", {26'd0, out_prd_0}, 32'd42);
            check("t42_hold2", {26'd0, out_prd_2}, 32'd44);
        end
        out_ready = 1'b1;
        cycle();
        check("t42_release", {31'd0, obs_ready}, 32'd1);
        check("t42_new", {26'd0, out_prd_0}, 32'd45);

        // flush restore with same-cycle commit
        idle();
        in_valid = 1'b1;
        lv[0] = 1'b1; rd[0] = 5'd4; we[0] = 1'b1; tag[0] = 6'd33;
        cycle();
        check("t43_prd", {26'd0, out_prd_0}, 32'd33);
        rd[0] = 5'd6; tag[0] = 6'd34;
        flush = 1'b1;
        cen[0] = 1'b1; crd[0] = 5'd4; cprd[0] = 6'd50;
        cycle();
        check("t43_flush_rdy", {31'd0, obs_ready}, 32'd0);
        check("t43_ov", {31'd0, out_valid}, 32'd0);
        idle();
        in_valid = 1'b1;
        lv[0] = 1'b1; rs1[0] = 5'd4;
        cycle();
        check("t43_map4", {26'd0, out_prs1_0}, 32'd50);

        // register zero
        idle();
        in_valid = 1'b1;
        lv[0] = 1'b1; we[0] = 1'b1; tag[0] = 6'd60;
        lv[1] = 1'b1; we[1] = 1'b1; tag[1] = 6'd61;
        cen[0] = 1'b1; cprd[0] = 6'd55;
        cycle();
        check("t44_en", {29'd0, obs_alloc}, 32'd0);
        check("t44_prd", {26'd0, out_prd_0}, 32'd0);
        check("t44_prs1", {26'd0, out_prs1_0}, 32'd0);
        check("t44_prs2", {26'd0, out_prs2_1}, 32'd0);
        idle();
        flush = 1'b1;
        cycle();
        idle();
        in_valid = 1'b1;
        lv[0] = 1'b1;
        cycle();
        check("t44_after", {26'd0, out_prs1_0}, 32'd0);

        // reset during a stall drops the held group
        idle();
        in_valid = 1'b1;
        lv[0] = 1'b1; rd[0] = 5'd8; we[0] = 1'b1; tag[0] = 6'd20;
        cycle();
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        cycle();
        check("t37_ov", {31'd0, out_valid}, 32'd0);
        check("t37_prd", {26'd0, out_prd_0}, 32'd0);
        idle();

        for (int n = 0; n < 600; n++) begin
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            free_count = 6'($urandom_range(0, 4));
            flush = ($urandom % 20) == 0;
            rst = ($urandom % 80) == 0;
            for (int k = 0; k < 3; k++) begin
                lv[k] = ($urandom % 4) != 0;
                we[k] = ($urandom % 3) != 0;
                rs1[k] = 5'($urandom_range(0, 7));
                rs2[k] = 5'($urandom_range(0, 7));
                rd[k] = 5'($urandom_range(0, 7));
                if (($urandom % 5) == 0) rd[k] = 5'($urandom);
                tag[k] = 6'($urandom_range(1, 63));
                cen[k] = ($urandom % 3) == 0;
                crd[k] = 5'($urandom_range(0, 7));
                cprd[k] = 6'($urandom_range(1, 63));
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
